// File: rtl/dsp_pkg.sv
// Shared mode encodings and latency helper for the pipelined multiply-add/accumulate unit.
package dsp_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_MUL  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_MADD = 2'b01;
  localparam logic [MODE_W-1:0] MODE_MACC = 2'b10;
  localparam logic [MODE_W-1:0] MODE_MSUB = 2'b11;

  // Enabled cycles from input sample to out_valid.
  function automatic int unsigned latency(input int unsigned in_stages, input int unsigned mreg);
    return in_stages + mreg + 32'd1;
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Operation/result bus of dsp_mac_pipe: issue side (a/b/c/mode/tag) and result side (p/out_tag).
interface dsp_mac_pipe_if #(
  parameter int unsigned A_W   = 25,
  parameter int unsigned B_W   = 18,
  parameter int unsigned P_W   = 48,
  parameter int unsigned TAG_W = 4
);
  import dsp_pkg::*;

  logic              in_valid;
  logic [MODE_W-1:0] mode;
  logic [TAG_W-1:0]  tag;
  logic [A_W-1:0]    a;
  logic [B_W-1:0]    b;
  logic [P_W-1:0]    c;
  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [P_W-1:0]    p;

  modport master (
    output in_valid, mode, tag, a, b, c,
    input  out_valid, out_tag, p
  );

  modport slave (
    input  in_valid, mode, tag, a, b, c,
    output out_valid, out_tag, p
  );

endinterface

// File: rtl/dsp_delay_line.sv
// Clock-enabled register chain of DEPTH stages; DEPTH=0 is a plain wire.
module dsp_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce};
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (ce) begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-add/accumulate: input stages, optional product register,
// final P stage doing MUL/MADD/MACC/MSUB with c and control delayed to line up with the product.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int unsigned A_W       = 25,
  parameter int unsigned B_W       = 18,
  parameter int unsigned P_W       = 48,
  parameter int unsigned IN_STAGES = 2,
  parameter int unsigned MREG      = 1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  dsp_mac_pipe_if.slave bus
);

  localparam int unsigned M_W    = A_W + B_W;
  localparam int unsigned C_DLY  = IN_STAGES + MREG;
  localparam int unsigned CTRL_W = 1 + MODE_W + TAG_W;

  if (A_W < 2 || B_W < 2 || TAG_W < 1 || P_W < M_W || IN_STAGES > 2 || MREG > 1) begin : g_param_check
    $fatal(1, "dsp_mac_pipe: parameter out of range");
  end

  logic [A_W-1:0]    a_d;
  logic [B_W-1:0]    b_d;
  logic [M_W-1:0]    prod_c;
  logic [M_W-1:0]    prod_d;
  logic [P_W-1:0]    c_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              valid_d;
  logic [MODE_W-1:0] mode_d;
  logic [TAG_W-1:0]  tag_d;
  logic [P_W-1:0]    prod_ext;
  logic [P_W-1:0]    p_next_c;

  logic              out_valid_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [P_W-1:0]    p_q;

  dsp_delay_line #(.WIDTH(M_W), .DEPTH(IN_STAGES)) u_ab_dly (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   ({bus.a, bus.b}),
    .q   ({a_d, b_d})
  );

  // Full-precision signed product before the optional M register.
  assign prod_c = M_W'($signed(a_d)) * M_W'($signed(b_d));

  dsp_delay_line #(.WIDTH(M_W), .DEPTH(MREG)) u_m_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (prod_c),
    .q   (prod_d)
  );

  // c, valid, mode and tag ride alongside a/b through the input and M stages.
  dsp_delay_line #(.WIDTH(P_W), .DEPTH(C_DLY)) u_c_dly (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (bus.c),
    .q   (c_d)
  );

  dsp_delay_line #(.WIDTH(CTRL_W), .DEPTH(C_DLY)) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   ({bus.in_valid, bus.mode, bus.tag}),
    .q   (ctrl_d)
  );

  assign {valid_d, mode_d, tag_d} = ctrl_d;
  assign prod_ext = P_W'($signed(prod_d));

  // Final adder; MACC feeds back the result register itself, so chained MACCs see no hazard.
  always_comb begin
    p_next_c = prod_ext;
    case (mode_d)
      MODE_MUL:  p_next_c = prod_ext;
      MODE_MADD: p_next_c = c_d + prod_ext;
      MODE_MACC: p_next_c = p_q + prod_ext;
      MODE_MSUB: p_next_c = c_d - prod_ext;
      default:   p_next_c = prod_ext;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      p_q         <= '0;
    end else if (ce) begin
      out_valid_q <= valid_d;
      if (valid_d) begin
        p_q       <= p_next_c;
        out_tag_q <= tag_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboarded bench for dsp_mac_pipe at default parameters (latency 4).
module tb_dsp_mac_pipe;
  import dsp_pkg::*;

  localparam int unsigned AW  = 25;
  localparam int unsigned BW  = 18;
  localparam int unsigned PW  = 48;
  localparam int unsigned TW  = 4;
  localparam int unsigned INS = 2;
  localparam int unsigned MR  = 1;
  localparam int          LAT = int'(latency(INS, MR));

  typedef struct {
    logic [PW-1:0] p;
    logic [TW-1:0] tag;
    int            due;
  } exp_t;

  logic clk;
  logic rst;
  logic ce;

  int checks = 0;
  int errors = 0;
  int ecyc   = 0;
  exp_t sbq[$];
  logic [PW-1:0] acc_m = '0;

  dsp_mac_pipe_if #(.A_W(AW), .B_W(BW), .P_W(PW), .TAG_W(TW)) io ();

  dsp_mac_pipe #(
    .A_W(AW), .B_W(BW), .P_W(PW), .IN_STAGES(INS), .MREG(MR), .TAG_W(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference arithmetic in 64-bit, truncated to the result width.
  function automatic logic [PW-1:0] model(input logic [1:0] m, input logic [AW-1:0] av,
                                          input logic [BW-1:0] bv, input logic [PW-1:0] cv,
                                          input logic [PW-1:0] acc);
    longint pr, cs, ac, r;
    pr = longint'($signed(av)) * longint'($signed(bv));
    cs = longint'($signed(cv));
    ac = longint'($signed(acc));
    case (m)
      MODE_MUL:  r = pr;
      MODE_MADD: r = cs + pr;
      MODE_MACC: r = ac + pr;
      default:   r = cs - pr;
    endcase
    return r[PW-1:0];
  endfunction

  task automatic set_op(input bit v, input logic [1:0] m, input logic [TW-1:0] t,
                        input longint av, input longint bv, input longint cv);
    io.in_valid = v;
    io.mode     = m;
    io.tag      = t;
    io.a        = AW'(av);
    io.b        = BW'(bv);
    io.c        = PW'(cv);
  endtask

  task automatic set_idle();
    set_op(1'b0, MODE_MUL, '0, 0, 0, 0);
  endtask

  // One clock: push what the DUT samples, then score what it produces.
  task automatic sb_cycle();
    exp_t e;
    bit en;
    @(posedge clk);
    en = ce && rst;
    if (en) begin
      ecyc++;
      if (io.in_valid) begin
        e.p   = model(io.mode, io.a, io.b, io.c, acc_m);
        acc_m = e.p;
        e.tag = io.tag;
        e.due = ecyc + LAT - 1;
        sbq.push_back(e);
      end
    end
    #1;
    if (en) begin
      if (io.out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: p=%h tag=%h with nothing outstanding", io.p, io.out_tag);
        end else begin
          e = sbq.pop_front();
          checks += 2;
          if (io.p !== e.p) begin
            errors++;
            $display("FAIL result_p: got %h expected %h", io.p, e.p);
          end
          if (io.out_tag !== e.tag) begin
            errors++;
            $display("FAIL result_tag: got %h expected %h", io.out_tag, e.tag);
          end
          if (ecyc != e.due) begin
            errors++;
            $display("FAIL result_latency: arrived at cycle %0d expected %0d", ecyc, e.due);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].due <= ecyc) begin
        checks++;
        errors++;
        e = sbq.pop_front();
        $display("FAIL missing_result: expected p=%h tag=%h at cycle %0d, got out_valid=0", e.p, e.tag, e.due);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce  = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (io.p !== '0) begin errors++; $display("FAIL reset_p: got %h expected 0", io.p); end
    if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", io.out_valid); end
    if (io.out_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h expected 0", io.out_tag); end
    rst = 1'b1;
  endtask

  task automatic test_mul();
    set_op(1'b1, MODE_MUL, 4'h5, 3, -5, 0);
    sb_cycle();
    set_idle();
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.p !== 48'hFFFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL mul_neg: p=%h expected ffffffffff f1", io.p);
    end
  endtask

  task automatic test_madd_msub();
    set_op(1'b1, MODE_MADD, 4'h1, 7, 6, 100);
    sb_cycle();
    set_op(1'b1, MODE_MSUB, 4'h2, 7, 6, 100);
    sb_cycle();
    set_idle();
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.p !== 48'd58) begin
      errors++;
      $display("FAIL msub_final: p=%0d expected 58", io.p);
    end
  endtask

  task automatic test_macc_stream();
    set_op(1'b1, MODE_MUL,  4'h3, 1, 2, 0);
    sb_cycle();
    set_op(1'b1, MODE_MACC, 4'h4, 2, 2, 0);
    sb_cycle();
    set_idle();
    sb_cycle();
    set_op(1'b1, MODE_MACC, 4'h5, 3, 2, 0);
    sb_cycle();
    set_op(1'b1, MODE_MACC, 4'h6, 4, 2, 0);
    sb_cycle();
    set_idle();
    repeat (LAT - 3) sb_cycle();
    checks += 2;
    if (io.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL macc_bubble_valid: got %b expected 0", io.out_valid);
    end
    if (io.p !== 48'd6) begin
      errors++;
      $display("FAIL macc_bubble_hold: p=%0d expected 6", io.p);
    end
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.p !== 48'd20) begin
      errors++;
      $display("FAIL macc_final: p=%0d expected 20", io.p);
    end
  endtask

  task automatic test_ce_stall();
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, MODE_MUL, TW'(i + 1), 10 + i, -3, 0);
      sb_cycle();
    end
    set_idle();
    sb_cycle();
    ce = 1'b0;
    set_op(1'b1, MODE_MUL, 4'hF, 99, 99, 0);
    for (int s = 0; s < 2; s++) begin
      sb_cycle();
      checks += 3;
      if (io.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid_hold: got %b expected 1", io.out_valid);
      end
      if (io.p !== PW'(-30)) begin
        errors++;
        $display("FAIL stall_p_hold: p=%h expected %h", io.p, PW'(-30));
      end
      if (io.out_tag !== 4'h1) begin
        errors++;
        $display("FAIL stall_tag_hold: got %h expected 1", io.out_tag);
      end
    end
    ce = 1'b1;
    set_idle();
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.out_tag !== 4'h3) begin
      errors++;
      $display("FAIL stall_last_tag: got %h expected 3", io.out_tag);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, MODE_MUL, TW'(i + 4), 5 + i, 7, 0);
      sb_cycle();
    end
    set_idle();
    rst = 1'b0;
    #1;
    checks += 2;
    if (io.p !== '0) begin errors++; $display("FAIL midreset_p: got %h expected 0", io.p); end
    if (io.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", io.out_valid); end
    sbq.delete();
    acc_m = '0;
    repeat (2) sb_cycle();
    rst = 1'b1;
    repeat (LAT + 2) sb_cycle();
    checks++;
    if (io.p !== '0) begin
      errors++;
      $display("FAIL midreset_stale: p=%h expected 0 after release", io.p);
    end
    set_op(1'b1, MODE_MUL, 4'h9, 2, 2, 0);
    sb_cycle();
    set_idle();
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.p !== 48'd4) begin
      errors++;
      $display("FAIL midreset_new_mul: p=%0d expected 4", io.p);
    end
  endtask

  task automatic test_wrap();
    set_op(1'b1, MODE_MADD, 4'hA, 1, 1, 64'h7FFF_FFFF_FFFF);
    sb_cycle();
    set_op(1'b1, MODE_MUL, 4'hB, -(64'sd1 <<< 24), -(64'sd1 <<< 17), 0);
    sb_cycle();
    set_idle();
    repeat (LAT + 1) sb_cycle();
    checks++;
    if (io.p !== 48'h0200_0000_0000) begin
      errors++;
      $display("FAIL wrap_full_product: p=%h expected 020000000000", io.p);
    end
  endtask

  initial begin
    rst = 1'b0;
    ce  = 1'b1;
    set_idle();
    test_reset();
    test_mul();
    test_madd_msub();
    test_macc_stream();
    test_ce_stall();
    test_reset_midflight();
    test_wrap();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never appeared, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised pipelined multiply-add/accumulate unit.
- Generalises the fixed DSP48E1 wrapper in the FPDSP datapath: configurable operand widths and pipeline depths, per-operation mode, valid tracking, clock enable and tag passthrough.
- Written behaviourally so synthesis maps it onto DSP slices. The C operand is delayed internally so it aligns with the product at the final adder.

Parameters:
- A_W, 25, signed A operand width.
- B_W, 18, signed B operand width.
- P_W, 48, result/C width; must be >= A_W+B_W.
- IN_STAGES, 2, input register stages on A/B/mode/tag/valid (0..2).
- MREG, 1, multiplier output register (0 or 1).
- TAG_W, 4, width of user tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; low freezes every pipeline register, including P.
- in_valid  in  1  operation present on inputs this cycle (sampled only when ce=1).
- mode  in  2  operation select, see Behaviour.
- tag  in  TAG_W  user tag, returned with the result.
- a  in  A_W  signed multiplicand.
- b  in  B_W  signed multiplier.
- c  in  P_W  signed addend, sampled in the same cycle as a/b.
- out_valid  out  1  p/out_tag hold a new result this cycle.
- out_tag  out  TAG_W  tag of the result on p.
- p  out  P_W  signed result register.

Behaviour:
- Reset (rst=0, async) clears all pipeline registers, valid bits, p, out_tag and out_valid to 0. Deassertion is synchronous to clk. Reset mid-flight discards all in-flight operations.
- Latency is L = IN_STAGES + MREG + 1 cycles (of ce=1) from in_valid sample to out_valid. Throughput is one operation per enabled cycle.
- The c operand passes through a delay of IN_STAGES + MREG registers, so it reaches the final adder together with its product. mode, tag and valid travel the same path.
- Modes, evaluated at the P stage:
  - 00 MUL: p = a*b.
  - 01 MADD: p = a*b + c.
  - 10 MACC: p = p + a*b.
  - 11 MSUB: p = c - a*b.
- Width rules: the product is the full A_W+B_W signed value, sign-extended to P_W. All sums wrap modulo 2^P_W. There is no saturation and no overflow flag.
- The P stage updates p/out_tag only when its incoming valid is 1 and ce=1. On bubbles p holds its value and out_valid=0.
- out_valid is registered and high for exactly one enabled cycle per result. While ce=0, all outputs hold, including out_valid.
- MACC uses the current p register, which holds the last valid result. Back-to-back MACC operations with no bubbles chain correctly with no hazard, because accumulation happens at the final stage. Bubbles between MACC operations do not disturb the accumulator.
- To start a new accumulation, issue MUL or MADD first; MACC never implicitly clears p.
- IN_STAGES=0 and MREG=0 give L=1 (only the P register).
- Parameter values out of range are a fatal elaboration error.

Decomposition:
- Package dsp_pkg holds:
  - mode encoding constants MODE_MUL=2'b00, MODE_MADD=2'b01, MODE_MACC=2'b10, MODE_MSUB=2'b11;
  - a function returning latency L from IN_STAGES/MREG, shared with the testbench.
- One sub-module, dsp_delay_line (params WIDTH, DEPTH; ports clk, rst, ce, d, q). It is a register chain with async active-low reset to zero and pass-through when DEPTH=0.
- dsp_delay_line is used for the A/B/mode/tag/valid input stages and for the c alignment delay.

Test Plan (defaults, L=4):
- MUL a=3, b=-5 -> out_valid exactly 4 cycles later with p=48'hFFFF_FFFF_FFF1 (-15); out_tag equals the input tag.
- MADD a=7, b=6, c=100 -> p=142. MSUB a=7, b=6, c=100 -> p=58. Issued back-to-back, they appear on consecutive cycles.
- Stream of b=2 with a=1,2,3,4: MUL, MACC, bubble, MACC, MACC -> p sequence 2, 6, 12, 20. out_valid is low during the bubble cycle and p holds 6.
- Drop ce for 2 cycles while 3 operations are in flight -> results are delayed by exactly 2 cycles, values and tags unchanged, and no duplicate out_valid pulses.
- Assert rst mid-stream with 3 operations in flight -> p=0 and out_valid=0 immediately. After release, no stale results emerge, and a new MUL a=2, b=2 returns 4 after 4 cycles.
- Wrap: MADD c=48'h7FFF_FFFF_FFFF, a=1, b=1 -> p=48'h8000_0000_0000. MUL a=-2^24, b=-2^17 -> p=2^41 with full product precision.
